// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the decode/execute stage and the HI/LO multiply/divide unit.
interface hilo_muldiv_if #(
    parameter int DATA_W = 32
);
    logic              op_valid;
    logic              op_ready;
    logic [5:0]        functcode;
    logic [DATA_W-1:0] rs_content;
    logic [DATA_W-1:0] rt_content;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              busy;
    logic              done;
    logic              div_zero;

    modport master (
        output op_valid, functcode, rs_content, rt_content,
        input  op_ready, hi, lo, busy, done, div_zero
    );

    modport slave (
        input  op_valid, functcode, rs_content, rt_content,
        output op_ready, hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one shift-add or restoring step per cycle.
// Optional macro HILO_MUL_EARLY_OUT_EN ends a multiply once the remaining multiplier is zero.
module hilo_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    hilo_muldiv_if.slave  bus
);
    localparam int W = DATA_W;

    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t         state_q, state_d;
    logic [4:0]     count_q, count_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   divisor_q, divisor_d;
    logic [W-1:0]   rs_q, rs_d;
    logic           is_div_q, is_div_d;
    logic           neg_res_q, neg_res_d;
    logic           neg_rem_q, neg_rem_d;
    logic           dz_q, dz_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           done_q, done_d;
    logic           div_zero_q, div_zero_d;

    logic           op_signed;
    logic [W-1:0]   a_mag, b_mag;
    logic [W-1:0]   mplier_next;
    logic [W:0]     rem_shift;
    logic           sub_ok;
    logic [2*W-1:0] prod_signed;

    assign bus.op_ready = (state_q == S_IDLE);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;

    // Odd function codes are the unsigned variants.
    assign op_signed   = ~bus.functcode[0];
    assign a_mag       = (op_signed && bus.rs_content[W-1]) ? -bus.rs_content : bus.rs_content;
    assign b_mag       = (op_signed && bus.rt_content[W-1]) ? -bus.rt_content : bus.rt_content;
    assign mplier_next = mplier_q >> 1;
    assign rem_shift   = {rem_q, quo_q[W-1]};
    assign sub_ok      = (rem_shift >= {1'b0, divisor_q});
    assign prod_signed = neg_res_q ? -acc_q : acc_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        divisor_d  = divisor_q;
        rs_d       = rs_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.op_valid) begin
                    case (bus.functcode)
                        FN_MTHI: hi_d = bus.rs_content;
                        FN_MTLO: lo_d = bus.rs_content;
                        FN_MULT, FN_MULTU: begin
                            acc_d     = '0;
                            mcand_d   = {{W{1'b0}}, a_mag};
                            mplier_d  = b_mag;
                            neg_res_d = op_signed & (bus.rs_content[W-1] ^ bus.rt_content[W-1]);
                            neg_rem_d = 1'b0;
                            dz_d      = 1'b0;
                            is_div_d  = 1'b0;
                            count_d   = '0;
                            state_d   = S_MUL;
                        end
                        FN_DIV, FN_DIVU: begin
                            rem_d     = '0;
                            quo_d     = a_mag;
                            divisor_d = b_mag;
                            rs_d      = bus.rs_content;
                            neg_res_d = op_signed & (bus.rs_content[W-1] ^ bus.rt_content[W-1]);
                            neg_rem_d = op_signed & bus.rs_content[W-1];
                            dz_d      = (bus.rt_content == '0);
                            is_div_d  = 1'b1;
                            count_d   = '0;
                            state_d   = S_DIV;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_next;
                count_d  = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = S_FIX;
                end
`ifdef HILO_MUL_EARLY_OUT_EN
                if (mplier_next == '0) begin
                    state_d = S_FIX;
                end
`endif
            end
            S_DIV: begin
                // A zero divisor always subtracts, so the quotient fills with ones naturally.
                rem_d   = sub_ok ? (rem_shift[W-1:0] - divisor_q) : rem_shift[W-1:0];
                quo_d   = {quo_q[W-2:0], sub_ok};
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_signed[2*W-1:W];
                    lo_d = prod_signed[W-1:0];
                end else if (dz_q) begin
                    hi_d       = rs_q;
                    lo_d       = '1;
                    div_zero_d = 1'b1;
                end else begin
                    hi_d = neg_rem_q ? -rem_q : rem_q;
                    lo_d = neg_res_q ? -quo_q : quo_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            rs_q       <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            divisor_q  <= divisor_d;
            rs_q       <= rs_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Sequential multiply/divide unit that owns the architectural HI and LO registers. It consumes MULT, MULTU, DIV, DIVU, MTHI and MTLO requests from the decode/execute stage and computes them iteratively. It presents HI/LO to the MFHI/MFLO datapath and exposes a ready/busy handshake so the pipeline can stall while an operation is in flight.

## Interface
Parameters:
- `DATA_W`, 32, operand and HI/LO width; only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  request strobe, sampled on `clk`.
- `op_ready`  out  1  high only in IDLE; a request is accepted on an edge where `op_valid && op_ready`.
- `functcode`  in  6  operation code:
  - 0x18 MULT, 0x19 MULTU, 0x1a DIV, 0x1b DIVU, 0x11 MTHI, 0x13 MTLO.
  - Any other value accepted in IDLE is a no-op.
- `rs_content`  in  32  operand A; dividend; MTHI/MTLO source.
- `rt_content`  in  32  operand B; multiplier; divisor.
- `hi`  out  32  HI register, driven directly from a flop.
- `lo`  out  32  LO register, driven directly from a flop.
- `busy`  out  1  equal to `!op_ready`.
- `done`  out  1  one-cycle pulse, high in the cycle after HI/LO are written by MULT/MULTU/DIV/DIVU.
- `div_zero`  out  1  one-cycle pulse, coincident with `done`, when the completed DIV/DIVU had `rt_content == 0`.

## Operation
- Reset values:
  - `hi`, `lo`, `done`, `div_zero` = 0.
  - FSM = IDLE, so `op_ready` = 1 and `busy` = 0.
- FSM states: IDLE, MUL, DIV, FIX.
- Transitions from IDLE on accept:
  - MTHI: `hi` ← `rs_content` on the accept edge; stays IDLE.
  - MTLO: `lo` ← `rs_content` on the accept edge; stays IDLE.
  - MULT/MULTU: operands are latched; signed ops take magnitudes and record the result sign. Go to MUL with count 0.
  - DIV/DIVU: same latching and sign capture. Go to DIV with count 0.
- MUL: one shift-add step per cycle on 32-bit magnitudes into a 64-bit accumulator. After 32 steps, go to FIX.
- DIV: one restoring shift-subtract step per cycle, giving a 32-bit quotient and remainder. After 32 steps, go to FIX.
- FIX: apply sign correction, write `hi`/`lo`, go to IDLE.
- Result rules:
  - MULT: {hi,lo} = signed 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
  - DIVU: unsigned quotient and remainder.
- Boundary conditions:
  - Divide by zero (DIV or DIVU): lo = 0xFFFFFFFF, hi = `rs_content`; `div_zero` pulses. Latency is normal.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (wraps).
  - MULT 0x80000000 × 0x80000000: {hi,lo} = 0x40000000_00000000.
- Requests while busy: `op_valid` is ignored and nothing is queued. The requester must hold the request until `op_ready`.
- HI/LO are never partially updated. During MUL/DIV they hold their previous values, so MFHI/MFLO issued during busy read stale data; the pipeline stalls on `busy`.
- Reset mid-operation: the operation aborts immediately, all state returns to reset values, and no `done` is produced.

## Timing
- Edge 0 is the accepting edge.
- MULT/MULTU/DIV/DIVU:
  - Edges 1–32: iteration steps.
  - Edge 33: FIX writes `hi`/`lo`; `done` is high in the cycle after edge 33.
  - `op_ready` returns high in that same cycle. A new request can be accepted at edge 34.
  - Total: 34 edges from accept to HI/LO update.
- MTHI/MTLO: update visible after edge 0. `op_ready` stays high, so back-to-back MTHI/MTLO is allowed every cycle.
- `done` and `div_zero` are deasserted at every other edge.

## Configuration
- `HILO_MUL_EARLY_OUT_EN`
  - Defined: in MUL, when the remaining multiplier magnitude is zero after a step, the FSM goes to FIX. MUL occupies max(1, k+1) cycles, where k is the index of the highest set bit of |multiplier|. HI/LO update at edge k+2, with a minimum of edge 2 for a zero multiplier.
  - Undefined: fixed 34-edge latency for all multiplies.
  - Division latency and all results are identical in both builds.

## Test plan
- Reset, then MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF → after edge 33, hi=0xFFFFFFFE, lo=0x00000001, `done` pulses once.
- MULT rs=0xFFFFFFFD (-3) rt=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. `op_valid` held high during busy with MTHI is not accepted; hi is unchanged until FIX.
- DIV rs=0xFFFFFFF9 (-7) rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=100 rt=7 → lo=14, hi=2.
- DIVU rs=0x1234 rt=0 → lo=0xFFFFFFFF, hi=0x1234, `div_zero` and `done` pulse together. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0xAAAA5555 then MTLO 0x5555AAAA on consecutive cycles → hi and lo each update one edge after their request. Then start MULT and assert `rst_n`=0 at edge 10 → hi=lo=0, `op_ready`=1, no `done`.
- With `HILO_MUL_EARLY_OUT_EN`: MULTU rs=5 rt=0 → result 0 at edge 2; MULTU rs=5 rt=6 (k=2) → lo=30 at edge 4. Without the macro, both complete at edge 33.
